// File: rtl/pulse_sync_sched.sv
// rtl/pulse_sync_sched.sv - round-robin scheduler issuing spaced pulses into a shared toggle synchroniser
// Requesters post one-cycle events; one is granted per syncPulse, with at least GAP+1 cycles between pulses.
module pulse_sync_sched #(
  parameter int NREQ = 4,
  parameter int GAP  = 6
) (
  input  logic            genClk,
  input  logic            hardReset_n,
  input  logic            enable,
  input  logic [NREQ-1:0] reqPulse,
  input  logic            ovfClear,
  output logic            syncPulse,
  output logic [2:0]      chanId,
  output logic [NREQ-1:0] grantVec,
  output logic [NREQ-1:0] pendingVec,
  output logic [NREQ-1:0] ovfVec,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, SPACE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      space_cnt;
  logic [2:0]      last_grant;
  logic [2:0]      winner;
  logic [2:0]      idx;
  logic [7:0]      pend8;
  logic [NREQ-1:0] win_vec;
  logic [NREQ-1:0] clr_vec;
  logic            start;

  // Walk from farthest to nearest so the first pending slot after last_grant wins.
  always_comb begin
    pend8  = 8'(pendingVec);
    winner = last_grant;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = 3'((int'(last_grant) + k) % NREQ);
      if (pend8[idx]) winner = idx;
    end
  end

  assign win_vec = NREQ'(1) << winner;
  assign clr_vec = (state == ISSUE) ? (NREQ'(1) << chanId) : '0;

  // The final SPACE cycle may launch the next grant directly, giving GAP+1 spacing.
  assign start = enable && (|pendingVec) &&
                 ((state == IDLE) || ((state == SPACE) && (space_cnt == 4'd0)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = SPACE;
      SPACE:   if (space_cnt == 4'd0) state_nxt = start ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge genClk or negedge hardReset_n) begin
    if (!hardReset_n) begin
      state      <= IDLE;
      space_cnt  <= '0;
      syncPulse  <= 1'b0;
      grantVec   <= '0;
      chanId     <= '0;
      pendingVec <= '0;
      ovfVec     <= '0;
      busy       <= 1'b0;
      last_grant <= 3'(NREQ - 1);
    end else begin
      state      <= state_nxt;
      syncPulse  <= start;
      grantVec   <= start ? win_vec : '0;
      busy       <= (state_nxt != IDLE);
      // A request coinciding with its own clear re-queues; otherwise a busy slot overflows.
      pendingVec <= (pendingVec & ~clr_vec) | reqPulse;
      ovfVec     <= (ovfVec & ~{NREQ{ovfClear}}) | (reqPulse & pendingVec & ~clr_vec);
      if (start) begin
        chanId     <= winner;
        last_grant <= winner;
      end
      if (state == ISSUE) space_cnt <= 4'(GAP - 1);
      else if ((state == SPACE) && (space_cnt != 4'd0)) space_cnt <= space_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_pulse_sync_sched.sv
// tb/tb_pulse_sync_sched.sv - self-checking bench for pulse_sync_sched against a cycle-level event model
// The model reasons in terms of grant times and pending sets, not FSM states.
module tb_pulse_sync_sched;
  localparam int NREQ = 4;
  localparam int GAP  = 6;

  logic            genClk = 1'b0;
  logic            hardReset_n;
  logic            enable;
  logic [NREQ-1:0] reqPulse;
  logic            ovfClear;
  logic            syncPulse;
  logic [2:0]      chanId;
  logic [NREQ-1:0] grantVec, pendingVec, ovfVec;
  logic            busy;

  pulse_sync_sched #(.NREQ(NREQ), .GAP(GAP)) dut (
    .genClk(genClk), .hardReset_n(hardReset_n), .enable(enable),
    .reqPulse(reqPulse), .ovfClear(ovfClear), .syncPulse(syncPulse),
    .chanId(chanId), .grantVec(grantVec), .pendingVec(pendingVec),
    .ovfVec(ovfVec), .busy(busy)
  );

  always #5 genClk = ~genClk;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [NREQ-1:0] m_pend, m_ovf, m_grant;
  logic            m_sync, m_busy;
  int              m_chan, m_lastg, last_issue, cyc;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_grant = '0; m_sync = 1'b0; m_busy = 1'b0;
    m_chan = 0; m_lastg = NREQ - 1; last_issue = -1000; cyc = 0;
  endtask

  // Advance the model from cycle cyc to cyc+1 given the inputs held during cyc.
  task automatic model_step(input logic [NREQ-1:0] req, input logic en, input logic oc);
    logic [NREQ-1:0] clr;
    bit issue;
    int w;
    clr   = m_sync ? NREQ'(1 << m_chan) : '0;
    issue = en && (m_pend != 0) && (cyc >= last_issue + GAP);
    w = m_lastg;
    if (issue) begin
      for (int k = 1; k <= NREQ; k++)
        if (m_pend[(m_lastg + k) % NREQ]) begin
          w = (m_lastg + k) % NREQ;
          break;
        end
      m_chan = w; m_lastg = w; last_issue = cyc + 1;
    end
    m_sync  = issue;
    m_grant = issue ? NREQ'(1 << w) : '0;
    m_ovf   = (oc ? '0 : m_ovf) | (req & m_pend & ~clr);
    m_pend  = (m_pend & ~clr) | req;
    cyc++;
    m_busy  = (cyc >= last_issue) && (cyc <= last_issue + GAP);
  endtask

  // Apply inputs for one cycle, clock it, then compare at the following negedge.
  task automatic tick(input logic [NREQ-1:0] req, input logic en = 1'b1, input logic oc = 1'b0);
    reqPulse = req; enable = en; ovfClear = oc;
    @(posedge genClk);
    model_step(req, en, oc);
    @(negedge genClk);
    chk("pendingVec", int'(pendingVec), int'(m_pend));
    chk("ovfVec",     int'(ovfVec),     int'(m_ovf));
    chk("syncPulse",  int'(syncPulse),  int'(m_sync));
    chk("grantVec",   int'(grantVec),   int'(m_grant));
    chk("chanId",     int'(chanId),     m_chan);
    chk("busy",       int'(busy),       int'(m_busy));
  endtask

  task automatic do_reset();
    hardReset_n = 1'b0; reqPulse = '0; enable = 1'b1; ovfClear = 1'b0;
    #1;
    chk("rst_sync",  int'(syncPulse),  0);
    chk("rst_grant", int'(grantVec),   0);
    chk("rst_chan",  int'(chanId),     0);
    chk("rst_pend",  int'(pendingVec), 0);
    chk("rst_ovf",   int'(ovfVec),     0);
    chk("rst_busy",  int'(busy),       0);
    model_reset();
    @(posedge genClk);
    @(negedge genClk);
    hardReset_n = 1'b1;
  endtask

  int first_t, second_t, nsync;
  int order[$];
  int times[$];

  initial begin
    @(negedge genClk);
    do_reset();

    // single request: pending at +1, grant at +2, busy for GAP+1 cycles
    tick(4'b0001);
    chk("lit_pend0", int'(pendingVec), 1);
    tick(4'b0000);
    chk("lit_sync0", int'(syncPulse), 1);
    chk("lit_grant0", int'(grantVec), 1);
    for (int i = 0; i < GAP; i++) begin
      tick(4'b0000);
      chk("lit_busy_space", int'(busy), 1);
    end
    tick(4'b0000);
    chk("lit_idle", int'(busy), 0);

    // all four at once: ordered grants spaced GAP+1
    do_reset();
    tick(4'b1111);
    order.delete(); times.delete();
    for (int t = 2; t < 32; t++) begin
      tick(4'b0000);
      if (syncPulse) begin order.push_back(int'(chanId)); times.push_back(t); end
    end
    chk("lit_ngrants", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      chk("lit_order", order[i], i);
      chk("lit_time", times[i], 2 + i * (GAP + 1));
    end
    chk("lit_no_ovf", int'(ovfVec), 0);

    // back-to-back on one requester: overflow, one grant, clear
    do_reset();
    tick(4'b0100);
    tick(4'b0100);
    chk("lit_ovf2", int'(ovfVec), 4);
    nsync = int'(syncPulse);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000);
      nsync += int'(syncPulse);
    end
    chk("lit_single_grant", nsync, 1);
    tick(4'b0000, 1'b1, 1'b1);
    chk("lit_ovf_clr", int'(ovfVec), 0);

    // request during own ISSUE re-queues and is granted GAP+1 later
    do_reset();
    tick(4'b0010);
    tick(4'b0000);
    first_t = cyc;
    tick(4'b0010);
    chk("lit_requeue", int'(pendingVec[1]), 1);
    chk("lit_requeue_ovf", int'(ovfVec), 0);
    second_t = -1;
    for (int i = 0; i < 12; i++) begin
      tick(4'b0000);
      if (syncPulse && second_t < 0) second_t = cyc;
    end
    chk("lit_regrant_gap", second_t - first_t, GAP + 1);

    // disabled: requests accumulate, grant one cycle after enable returns
    do_reset();
    tick(4'b0101, 1'b0);
    nsync = 0;
    for (int i = 0; i < 5; i++) begin
      tick(4'b0000, 1'b0);
      nsync += int'(syncPulse);
    end
    chk("lit_disabled_sync", nsync, 0);
    chk("lit_disabled_pend", int'(pendingVec), 5);
    tick(4'b0000, 1'b1);
    chk("lit_en_sync", int'(syncPulse), 1);
    chk("lit_en_chan", int'(chanId), 0);

    // reset during SPACE with pending work
    do_reset();
    tick(4'b0001);
    tick(4'b0000);
    tick(4'b0110);
    tick(4'b0000);
    chk("lit_space_pend", int'(pendingVec), 6);
    do_reset();
    tick(4'b0000);
    chk("lit_post_rst_sync1", int'(syncPulse), 0);
    tick(4'b0000);
    chk("lit_post_rst_sync2", int'(syncPulse), 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [NREQ-1:0] r;
      r = '0;
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 9) == 0) r[b] = 1'b1;
      tick(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
